// File: rtl/alu_tx_pkg.sv
// Shared definitions for the ALU-result-to-UART transmit controller:
// FSM state encoding, byte width and the default header byte value.
package alu_tx_pkg;

   localparam int unsigned BYTE_W       = 8;
   localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      SEND      = 3'd2,
      WAIT_ACK  = 3'd3,
      WAIT_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/result_fifo.sv
// Two-entry FIFO buffering ALU result words ahead of the byte serialiser.
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module result_fifo #(
   parameter int unsigned Width = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             wr_en,
   input  logic [Width-1:0] wr_data,
   input  logic             rd_en,
   output logic [Width-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   logic [Width-1:0] mem_q [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       cnt_q;
   logic             wr_ok, rd_ok;

   assign full    = (cnt_q == 2'd2);
   assign empty   = (cnt_q == 2'd0);
   assign wr_ok   = wr_en && (!full || rd_en);
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem_q[rd_ptr_q];

   // Storage: when full with a simultaneous pop, the slot being read is overwritten
   // at the same edge that the reader captures it, so no data is lost.
   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (wr_ok) wr_ptr_q <= ~wr_ptr_q;
         if (rd_ok) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + 2'(wr_ok) - 2'(rd_ok);
      end
   end

endmodule

// File: rtl/alu_result_tx_ctrl.sv
// Takes ALU result words, buffers them in a 2-entry FIFO and hands them to UART_TX
// one byte at a time (LSB first) over the P_DATA / DATA_VALID / BUSY handshake.
// An offered byte that is not acknowledged by TX_BUSY within ACK_TO cycles is re-offered.
// Optional: define ALU_TX_HDR_EN to prefix every word with the HDR_BYTE frame.
module alu_result_tx_ctrl
   import alu_tx_pkg::*;
#(
   parameter int unsigned Width  = 16,
   parameter int unsigned ACK_TO = 255
`ifdef ALU_TX_HDR_EN
   ,
   parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEF
`endif
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [Width-1:0] ALU_OUT,
   input  logic             OUT_VALID,
   input  logic             TX_BUSY,
   input  logic             CLR_DROP,
   output logic [7:0]       TX_P_DATA,
   output logic             TX_D_VALID,
   output logic             CTRL_BUSY,
   output logic             DROP_FLAG
);

   localparam int unsigned NBYTES   = Width / BYTE_W;
   localparam logic [1:0]  LAST_IDX = 2'(NBYTES - 1);
   localparam logic [7:0]  ACK_TO_C = 8'(ACK_TO);

   state_t           state_q, state_d;
   logic [Width-1:0] shift_q, shift_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [7:0]       to_cnt_q, to_cnt_d;
   logic             drop_q, drop_d;
   logic             pop, tx_valid;
   logic             fifo_full, fifo_empty;
   logic [Width-1:0] fifo_rd_data;
`ifdef ALU_TX_HDR_EN
   logic             hdr_q, hdr_d;
`endif

   result_fifo #(
      .Width (Width)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (OUT_VALID),
      .wr_data (ALU_OUT),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Next-state logic for the serialiser FSM and its datapath registers.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      to_cnt_d   = to_cnt_q;
      pop        = 1'b0;
      tx_valid   = 1'b0;
`ifdef ALU_TX_HDR_EN
      hdr_d      = hdr_q;
`endif
      case (state_q)
         IDLE: begin
            // A word arriving this cycle lands in the FIFO at the edge, so LOAD can pop it.
            if (!fifo_empty || OUT_VALID) state_d = LOAD;
         end
         LOAD: begin
            pop        = 1'b1;
            shift_d    = fifo_rd_data;
            byte_cnt_d = LAST_IDX;
`ifdef ALU_TX_HDR_EN
            hdr_d      = 1'b1;
`endif
            state_d    = SEND;
         end
         SEND: begin
            tx_valid = !TX_BUSY;
            if (tx_valid) begin
               to_cnt_d = 8'd0;
               state_d  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (TX_BUSY) begin
               state_d = WAIT_DONE;
            end else if (to_cnt_q == ACK_TO_C) begin
               state_d = SEND;
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
         end
         WAIT_DONE: begin
            if (!TX_BUSY) begin
`ifdef ALU_TX_HDR_EN
               if (hdr_q) begin
                  hdr_d   = 1'b0;
                  state_d = SEND;
               end else
`endif
               if (byte_cnt_q != 2'd0) begin
                  shift_d    = shift_q >> BYTE_W;
                  byte_cnt_d = byte_cnt_q - 2'd1;
                  state_d    = SEND;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Overflow: a write into a full FIFO without a pop loses the word; a set beats a clear.
   always_comb begin
      drop_d = drop_q;
      if (OUT_VALID && fifo_full && !pop) begin
         drop_d = 1'b1;
      end else if (CLR_DROP) begin
         drop_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         byte_cnt_q <= 2'd0;
         to_cnt_q   <= 8'd0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
         to_cnt_q   <= to_cnt_d;
         drop_q     <= drop_d;
      end
   end

`ifdef ALU_TX_HDR_EN
   // Header-pending bit: set on LOAD, cleared once the header frame completes.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) hdr_q <= 1'b0;
      else     hdr_q <= hdr_d;
   end
   assign TX_P_DATA = hdr_q ? HDR_BYTE : shift_q[BYTE_W-1:0];
`else
   assign TX_P_DATA = shift_q[BYTE_W-1:0];
`endif

   assign TX_D_VALID = tx_valid;
   assign CTRL_BUSY  = (state_q != IDLE) || !fifo_empty;
   assign DROP_FLAG  = drop_q;

endmodule

// File: tb/tb_alu_result_tx_ctrl.sv
// Self-checking bench for alu_result_tx_ctrl (Width=16, ACK_TO=4).
// A queue holds the byte stream each accepted word must produce; a compare process
// checks every strobe, the drop flag and busy against it on every falling clock edge.
module tb_alu_result_tx_ctrl;

   localparam int unsigned W   = 16;
   localparam int unsigned ACK = 4;
`ifdef ALU_TX_HDR_EN
   localparam int unsigned NFR = 3;
   localparam logic [7:0]  FIRST_BYTE_34 = 8'hA5;
`else
   localparam int unsigned NFR = 2;
   localparam logic [7:0]  FIRST_BYTE_34 = 8'h34;
`endif

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [W-1:0] ALU_OUT = '0;
   logic         OUT_VALID = 1'b0;
   logic         TX_BUSY = 1'b0;
   logic         CLR_DROP = 1'b0;
   logic [7:0]   TX_P_DATA;
   logic         TX_D_VALID;
   logic         CTRL_BUSY;
   logic         DROP_FLAG;

   alu_result_tx_ctrl #(
      .Width  (W),
      .ACK_TO (ACK)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .ALU_OUT    (ALU_OUT),
      .OUT_VALID  (OUT_VALID),
      .TX_BUSY    (TX_BUSY),
      .CLR_DROP   (CLR_DROP),
      .TX_P_DATA  (TX_P_DATA),
      .TX_D_VALID (TX_D_VALID),
      .CTRL_BUSY  (CTRL_BUSY),
      .DROP_FLAG  (DROP_FLAG)
   );

   always #5 CLK = ~CLK;

   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] exp_q [$];
   bit         ack_mode = 1'b1;
   bit         drop_exp = 1'b0;
   int         strobes = 0;
   int         last_strobe = -1;
   int         strobe_cyc = -1;
   logic [7:0] last_data = 8'h00;
   int         busy_fall = -1;
   int         ctrl_fall = -1;
   logic       prev_busy = 1'b0;
   logic       prev_ctrl = 1'b0;
   int         ov_cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference checker: runs every cycle outside reset.
   initial begin
      forever begin
         @(negedge CLK);
         if (!RST) begin
            check("drop_flag", 32'(DROP_FLAG), 32'(drop_exp));
            if (exp_q.size() > 0 && !OUT_VALID) check("ctrl_busy_held", 32'(CTRL_BUSY), 1);
            if (TX_D_VALID) begin
               strobes++;
               strobe_cyc = cyc;
               last_data  = TX_P_DATA;
               check("strobe_while_idle_tx", 32'(TX_BUSY), 0);
               check("strobe_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  check("strobe_data", 32'(TX_P_DATA), 32'(exp_q[0]));
                  if (ack_mode) void'(exp_q.pop_front());
               end
               if (!ack_mode) begin
                  if (last_strobe >= 0) check("reoffer_gap", cyc - last_strobe, ACK + 2);
                  last_strobe = cyc;
               end
            end
            if (prev_busy && !TX_BUSY) busy_fall = cyc;
            if (prev_ctrl && !CTRL_BUSY) ctrl_fall = cyc;
         end
         prev_busy = TX_BUSY;
         prev_ctrl = CTRL_BUSY;
      end
   end

   // UART_TX model: BUSY rises the cycle after a strobe and stays high for 10 cycles.
   initial begin
      forever begin
         @(negedge CLK);
         if (ack_mode && TX_D_VALID && !RST) begin
            @(posedge CLK);
            #1 TX_BUSY = 1'b1;
            repeat (10) @(posedge CLK);
            #1 TX_BUSY = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_word(input logic [15:0] w);
`ifdef ALU_TX_HDR_EN
      exp_q.push_back(8'hA5);
`endif
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
   endtask

   task automatic send(input logic [15:0] w, input bit acc, input bit clr);
      ALU_OUT   = w;
      OUT_VALID = 1'b1;
      CLR_DROP  = clr;
      if (acc) push_word(w);
      ov_cyc = cyc;
      tick();
      OUT_VALID = 1'b0;
      CLR_DROP  = 1'b0;
   endtask

   task automatic wait_strobe(input int n0);
      int k = 0;
      while (strobes <= n0 && k < 200) begin
         tick();
         k++;
      end
      check("strobe_seen", 32'(strobes > n0), 1);
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((CTRL_BUSY || TX_BUSY) && k < 1000) begin
         tick();
         k++;
      end
      check("idle_reached", 32'(CTRL_BUSY || TX_BUSY), 0);
      tick();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_p_data"},  32'(TX_P_DATA), 0);
      check({tag, "_d_valid"}, 32'(TX_D_VALID), 0);
      check({tag, "_ctrl_busy"}, 32'(CTRL_BUSY), 0);
      check({tag, "_drop"},    32'(DROP_FLAG), 0);
   endtask

   initial begin
      int s0, s1;
      #12;
      check_outputs_zero("reset");
      tick();
      RST = 1'b0;
      tick();
      tick();

      // Single word 0x1234: LSB first, first strobe two cycles after OUT_VALID.
      s0 = strobes;
      send(16'h1234, 1'b1, 1'b0);
      wait_strobe(s0);
      check("first_strobe_latency", strobe_cyc - ov_cyc, 2);
      check("first_byte_lit", 32'(last_data), 32'(FIRST_BYTE_34));
      wait_idle();
      check("word_strobe_count", strobes - s0, NFR);
      check("ctrl_busy_falls_after_tx", ctrl_fall - busy_fall, 1);
      check("last_byte_lit", 32'(last_data), 32'h12);
      check("queue_drained_1", exp_q.size(), 0);

      // Three back-to-back words while one is in flight: third is dropped.
      s0 = strobes;
      send(16'h1234, 1'b1, 1'b0);
      wait_strobe(s0);
      send(16'h0001, 1'b1, 1'b0);
      send(16'h0002, 1'b1, 1'b0);
      send(16'h0003, 1'b0, 1'b0);
      drop_exp = 1'b1;
      check("drop_set_lit", 32'(DROP_FLAG), 1);
      wait_idle();
      check("b2b_strobe_count", strobes - s0, 3 * NFR);
      check("last_b2b_byte_lit", 32'(last_data), 32'h00);
      check("queue_drained_2", exp_q.size(), 0);

      // Overflow coinciding with CLR_DROP keeps the flag set; a lone CLR_DROP clears it.
      s0 = strobes;
      send(16'h1234, 1'b1, 1'b0);
      wait_strobe(s0);
      send(16'h0005, 1'b1, 1'b0);
      send(16'h0006, 1'b1, 1'b0);
      send(16'h0007, 1'b0, 1'b1);
      check("drop_set_beats_clear", 32'(DROP_FLAG), 1);
      wait_idle();
      CLR_DROP = 1'b1;
      tick();
      CLR_DROP = 1'b0;
      drop_exp = 1'b0;
      check("drop_cleared", 32'(DROP_FLAG), 0);
      tick();

      // No acknowledge: the same byte is re-offered every ACK+2 cycles.
      ack_mode    = 1'b0;
      last_strobe = -1;
      s0 = strobes;
      send(16'h1234, 1'b1, 1'b0);
      repeat (40) tick();
      check("reoffer_count", strobes - s0, 7);
      check("reoffer_byte_lit", 32'(last_data), 32'(FIRST_BYTE_34));
      RST = 1'b1;
      exp_q.delete();
      tick();
      RST = 1'b0;
      ack_mode = 1'b1;
      tick();

      // Reset mid-word: outputs clear asynchronously and no further strobe follows.
      s0 = strobes;
      send(16'h1234, 1'b1, 1'b0);
      wait_strobe(s0);
      repeat (3) tick();
      #2;
      RST = 1'b1;
      exp_q.delete();
      #1;
      check_outputs_zero("async_reset");
      tick();
      tick();
      RST = 1'b0;
      s1 = strobes;
      repeat (20) tick();
      check("no_strobe_after_reset", strobes - s1, 0);

      // Fresh word after reset release.
      s0 = strobes;
      send(16'hBEEF, 1'b1, 1'b0);
      wait_idle();
      check("fresh_word_strobes", strobes - s0, NFR);
      check("fresh_last_byte_lit", 32'(last_data), 32'hBE);
      check("queue_drained_3", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
